enc_rlwe512: RTL

ENC_RLWE512 -- requirements
Module: enc_rlwe512

---
 rtl/rlwe_pkg.sv | 19 +
 rtl/rlwe_nc_mac.sv | 53 +++++
 rtl/enc_rlwe512.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rlwe_pkg.sv
// Shared constants, coefficient type and FSM encoding for the RLWE-512 encryptor.
package rlwe_pkg;

    localparam int unsigned N      = 512;
    localparam int unsigned LOG_Q  = 8;
    localparam int unsigned NQ     = N * LOG_Q;
    localparam int unsigned Q_HALF = 128;
    localparam int unsigned CNT_W  = $clog2(N);

    typedef logic [LOG_Q-1:0] coef_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rlwe_nc_mac.sv
// Negacyclic shift-accumulate lane: acc <= acc*x + bit*operand in Z_q[x]/(x^N+1).
module rlwe_nc_mac #(
    parameter int unsigned N     = rlwe_pkg::N,
    parameter int unsigned LOG_Q = rlwe_pkg::LOG_Q
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic               bit_i,
    input  logic [N*LOG_Q-1:0] op_i,
    output logic [N*LOG_Q-1:0] acc_o
);
    import rlwe_pkg::*;

    localparam int unsigned W = N * LOG_Q;

    logic [W-1:0]     acc_q;
    logic [W-1:0]     acc_d;
    logic [W-1:0]     rot;
    logic [LOG_Q-1:0] neg_top;

    // Multiply by x: shift coefficients up one slot, top coefficient wraps negated.
    always_comb begin
        neg_top = '0 - acc_q[W-1 -: LOG_Q];
        rot     = {acc_q[W-LOG_Q-1:0], neg_top};
    end

    // Next accumulator value: hold, clear, or shift plus conditional operand add.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            for (int i = 0; i < N; i++) begin
                acc_d[i*LOG_Q +: LOG_Q] = rot[i*LOG_Q +: LOG_Q]
                                        + (bit_i ? op_i[i*LOG_Q +: LOG_Q] : '0);
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/enc_rlwe512.sv
// RLWE encryption core: c1 = a*e1 + e2, c2 = p*e1 + e3 + (q/2)*m over Z_q[x]/(x^N+1).
// Products are formed bit-serially (Horner over e1, MSB first), N cycles per operation.
// Optional macro ENC_RLWE_NOISE_EN: when defined, e2/e3 are added; otherwise ignored.
module enc_rlwe512 #(
    parameter int unsigned N     = rlwe_pkg::N,
    parameter int unsigned LOG_Q = rlwe_pkg::LOG_Q
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*LOG_Q-1:0] a,
    input  logic [N*LOG_Q-1:0] p,
    input  logic [N-1:0]       e1,
    input  logic [N-1:0]       e2,
    input  logic [N-1:0]       e3,
    input  logic [N-1:0]       m,
    output logic [N*LOG_Q-1:0] c1,
    output logic [N*LOG_Q-1:0] c2,
    output logic               valid
);
    import rlwe_pkg::*;

    localparam int unsigned W  = N * LOG_Q;
    localparam int unsigned CW = $clog2(N);
    localparam logic [LOG_Q-1:0] HALF = LOG_Q'(1) << (LOG_Q - 1);

    state_t         state_q;
    state_t         state_d;
    logic           lane_clr;
    logic           lane_en;
    logic           add_en;
    logic [N-1:0]   sr_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   acc_a;
    logic [W-1:0]   acc_p;
    logic [W-1:0]   c1_q;
    logic [W-1:0]   c1_d;
    logic [W-1:0]   c2_q;
    logic [W-1:0]   c2_d;
    logic           valid_q;
    logic [N-1:0]   n2;
    logic [N-1:0]   n3;

`ifdef ENC_RLWE_NOISE_EN
    assign n2 = e2;
    assign n3 = e3;
`else
    logic unused_noise;
    assign n2           = '0;
    assign n3           = '0;
    assign unused_noise = ^{e2, e3};
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and datapath strobes.
    always_comb begin
        state_d  = state_q;
        lane_clr = 1'b0;
        lane_en  = 1'b0;
        add_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lane_clr = 1'b1;
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                lane_en = 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                add_en  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // e1 shift register (MSB feeds the lanes) and MUL cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (lane_clr) begin
            sr_q  <= e1;
            cnt_q <= '0;
        end else if (lane_en) begin
            sr_q  <= {sr_q[N-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    rlwe_nc_mac #(.N(N), .LOG_Q(LOG_Q)) u_lane_a (
        .clk   (clk),
        .rst   (rst),
        .clr_i (lane_clr),
        .en_i  (lane_en),
        .bit_i (sr_q[N-1]),
        .op_i  (a),
        .acc_o (acc_a)
    );

    rlwe_nc_mac #(.N(N), .LOG_Q(LOG_Q)) u_lane_p (
        .clk   (clk),
        .rst   (rst),
        .clr_i (lane_clr),
        .en_i  (lane_en),
        .bit_i (sr_q[N-1]),
        .op_i  (p),
        .acc_o (acc_p)
    );

    // Final per-coefficient additions: noise terms and message scaled by q/2.
    always_comb begin
        c1_d = '0;
        c2_d = '0;
        for (int i = 0; i < N; i++) begin
            c1_d[i*LOG_Q +: LOG_Q] = acc_a[i*LOG_Q +: LOG_Q] + LOG_Q'(n2[i]);
            c2_d[i*LOG_Q +: LOG_Q] = acc_p[i*LOG_Q +: LOG_Q] + LOG_Q'(n3[i])
                                   + (m[i] ? HALF : '0);
        end
    end

    // Ciphertext and valid registers; ciphertext holds until the next ADD.
    always_ff @(posedge clk) begin
        if (rst) begin
            c1_q    <= '0;
            c2_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= add_en;
            if (add_en) begin
                c1_q <= c1_d;
                c2_q <= c2_d;
            end
        end
    end

    assign c1    = c1_q;
    assign c2    = c2_q;
    assign valid = valid_q;

endmodule
